down_counter_timer: RTL and testbench

//   Synchronous loadable down counter / interval timer. It counts in the opposite direction
//   to the ripple up counter: it decrements from a programmed value to zero.
//   A one-cycle terminal-count pulse (tc) marks each time the count reaches zero.

---
 rtl/counter_pkg.sv | 7 +
 rtl/d_ff_sr.sv | 15 +
 rtl/down_counter_timer.sv | 85 ++++++++
 tb/tb_down_counter_timer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared state encoding for the down counter / interval timer.
package counter_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/d_ff_sr.sv
// Single-bit D flip-flop with synchronous active-high reset and clock enable.
module d_ff_sr (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= 1'b0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer with one-shot and auto-reload modes.
// States: IDLE | counter parked, en ignored;  RUN | counting down on en
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  state_t           state;
  state_t           st_nxt;
  logic             state_q;
  logic             is_one;
  logic             is_zero;

  assign state   = state_t'(state_q);
  assign busy    = (state == ST_RUN);
  assign is_one  = (count == WIDTH'(1));
  assign is_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst)       reload_reg <= '0;
    else if (load) reload_reg <= load_val;
  end

  always_comb begin
    cnt_nxt = count;
    tc_nxt  = 1'b0;
    st_nxt  = state;
    if (load) begin
      cnt_nxt = load_val;
      st_nxt  = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (state == ST_RUN && en) begin
      if (is_one) begin
        cnt_nxt = '0;
        tc_nxt  = 1'b1;
        st_nxt  = auto_reload ? ST_RUN : ST_IDLE;
      end else if (is_zero) begin
        // only reachable in auto-reload: the cycle after expiry restarts the period
        cnt_nxt = reload_reg;
      end else begin
        cnt_nxt = count - WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    d_ff_sr u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (cnt_nxt[i]),
      .q   (count[i])
    );
  end

  d_ff_sr u_tc (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (tc_nxt),
    .q   (tc)
  );

  d_ff_sr u_state (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (st_nxt),
    .q   (state_q)
  );

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus pushes expected outputs, monitor checks.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] count;
  logic       tc;
  logic       busy;

  typedef struct {
    string      name;
    logic [3:0] c;
    logic       t;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy)
  );

  // Monitor: outputs are valid every cycle; check one queued expectation per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_cmp++;
      if (count !== cur.c || tc !== cur.t || busy !== cur.b) begin
        n_bad++;
        $display("FAIL %s: got count=%h tc=%b busy=%b, expected count=%h tc=%b busy=%b",
                 cur.name, count, tc, busy, cur.c, cur.t, cur.b);
      end
    end
  end

  task automatic step(input logic r, input logic ld, input logic [3:0] v,
                      input logic e, input logic ar,
                      input logic [3:0] ec, input logic et, input logic eb,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; load = ld; load_val = v; en = e; auto_reload = ar;
    x.name = nm; x.c = ec; x.t = et; x.b = eb;
    exp_q.push_back(x);
  endtask

  initial begin
    // 1: reset beats load
    step(1, 1, 4'h9, 0, 0, 4'h0, 0, 0, "reset_c1");
    step(1, 1, 4'h9, 0, 0, 4'h0, 0, 0, "reset_c2");
    step(0, 0, 4'h0, 1, 0, 4'h0, 0, 0, "idle_after_reset");

    // 2: one-shot from 5
    step(0, 1, 4'h5, 0, 0, 4'h5, 0, 1, "os_load5");
    step(0, 0, 4'h0, 1, 0, 4'h4, 0, 1, "os_4");
    step(0, 0, 4'h0, 1, 0, 4'h3, 0, 1, "os_3");
    step(0, 0, 4'h0, 1, 0, 4'h2, 0, 1, "os_2");
    step(0, 0, 4'h0, 1, 0, 4'h1, 0, 1, "os_1");
    step(0, 0, 4'h0, 1, 0, 4'h0, 1, 0, "os_expire");
    for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 1, 0, 4'h0, 0, 0, "os_stay_zero");

    // 3: auto-reload from 3, period 4
    step(0, 1, 4'h3, 0, 1, 4'h3, 0, 1, "ar_load3");
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 4'h0, 1, 1, 4'h2, 0, 1, "ar_2");
      step(0, 0, 4'h0, 1, 1, 4'h1, 0, 1, "ar_1");
      step(0, 0, 4'h0, 1, 1, 4'h0, 1, 1, "ar_expire");
      step(0, 0, 4'h0, 1, 1, 4'h3, 0, 1, "ar_reload");
    end

    // 4: pause with en=0
    step(0, 1, 4'h4, 0, 0, 4'h4, 0, 1, "pz_load4");
    step(0, 0, 4'h0, 1, 0, 4'h3, 0, 1, "pz_3");
    step(0, 0, 4'h0, 1, 0, 4'h2, 0, 1, "pz_2");
    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 0, 0, 4'h2, 0, 1, "pz_hold");
    step(0, 0, 4'h0, 1, 0, 4'h1, 0, 1, "pz_1");
    step(0, 0, 4'h0, 1, 0, 4'h0, 1, 0, "pz_expire");

    // 5: reload mid-run wins over en
    step(0, 1, 4'h5, 0, 0, 4'h5, 0, 1, "ld_load5");
    step(0, 0, 4'h0, 1, 0, 4'h4, 0, 1, "ld_4");
    step(0, 0, 4'h0, 1, 0, 4'h3, 0, 1, "ld_3");
    step(0, 1, 4'hF, 1, 0, 4'hF, 0, 1, "ld_F_no_dec");
    step(0, 0, 4'h0, 1, 0, 4'hE, 0, 1, "ld_E");
    step(0, 0, 4'h0, 1, 0, 4'hD, 0, 1, "ld_D");

    // 6: load 0 stays idle; mid-run reset aborts without tc
    step(0, 1, 4'h0, 1, 1, 4'h0, 0, 0, "z_load0");
    step(0, 0, 4'h0, 1, 1, 4'h0, 0, 0, "z_idle_en");
    step(0, 0, 4'h0, 1, 1, 4'h0, 0, 0, "z_idle_en2");
    step(0, 1, 4'h8, 0, 0, 4'h8, 0, 1, "rs_load8");
    step(0, 0, 4'h0, 1, 0, 4'h7, 0, 1, "rs_7");
    step(0, 0, 4'h0, 1, 0, 4'h6, 0, 1, "rs_6");
    step(1, 0, 4'h0, 1, 0, 4'h0, 0, 0, "rs_abort");
    step(0, 0, 4'h0, 1, 0, 4'h0, 0, 0, "rs_idle_after");
    step(0, 0, 4'h0, 1, 0, 4'h0, 0, 0, "rs_idle_after2");

    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
